song_reader: RTL and testbench
==============================

Name: song_reader

Overview:
Sequencer that drives a note player: reads a song ROM and issues one note at a time as a note number plus a duration in beats. Pulses new_note, then waits for note_done before fetching the next entry. Sits between the top-level play/song controls and the note player; it is the initiator side of the load_new_note/note_done handshake.

Parameters:
IDX_W, 5, note index width; NOTES = 2^IDX_W = 32 entries per song
SONG_W, 2, song select width; 4 songs
ROM address width is SONG_W+IDX_W = 7. ROM data width is 12, packed as {note[5:0], duration[5:0]}.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
play  in  1  level; high = play, low = pause
song  in  SONG_W  song select
note_done  in  1  one-cycle pulse from the note player when the current note has finished
note  out  6  current note number; 0 = rest
duration  out  6  current note length in beats
new_note  out  1  one-cycle pulse; note and duration are valid in this cycle
song_done  out  1  end of song reached

Behaviour:
- Reset: state IDLE, index 0, note 0, duration 0, new_note 0, song_done 0. Reset mid-song abandons the song with no pulse.
- States: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE:
  - Stays here while play=0.
  - When play=1, latch song into cur_song, set index 0, go to FETCH.
- FETCH (1 cycle):
  - ROM address = {cur_song, index}. The ROM is synchronous with 1-cycle read latency.
  - Next state is ISSUE.
- ISSUE (1 cycle): ROM data is valid.
  - If duration field = 0 (end marker), go to DONE; no new_note is issued.
  - Otherwise load the note and duration registers and go to WAIT.
- WAIT:
  - new_note=1 in the first WAIT cycle only (registered pulse). It is never high in any other cycle.
  - note and duration hold stable from that cycle until the next load.
  - On note_done=1:
    - if index = NOTES-1, go to DONE;
    - otherwise index+1 and go to FETCH.
  - note_done outside WAIT is ignored.
- DONE:
  - song_done=1 (level) while in DONE.
  - Leave DONE for IDLE only when play=0, so holding play high does not auto-restart.
- Latency: play sampled high in IDLE at cycle 0 → new_note=1 at cycle 3. note_done at cycle t → next new_note at t+3.
- Pause: play=0 in FETCH, ISSUE, or WAIT returns to FETCH-hold.
  - The FSM freezes in a PAUSED condition with index preserved. Implement this as a hold flag; there is no extra state.
  - When play returns to 1, go to FETCH and re-issue the current index. The note restarts from the beginning.
  - play=0 has priority over a coincident note_done, so the index does not advance.
- Song change: if song ≠ cur_song in FETCH, ISSUE, or WAIT, latch the new song, set index 0, go to FETCH. No song_done is raised. This has priority over note_done.
- Index arithmetic is unsigned IDX_W bits. Wrap is never reached because index NOTES-1 always ends the song.

Optional Feature:
SONG_LOOP_EN.
- Defined: at end of song (end marker or last index), song_done is a one-cycle pulse, index resets to 0, and the FSM goes to FETCH. DONE is unreachable.
- Undefined: behaviour as above (song_done level held in DONE until play=0).

Decomposition:
- Shared package: state encoding, ROM field positions (NOTE_MSB=11, NOTE_LSB=6, DUR_MSB=5, DUR_LSB=0), END_MARKER duration = 0, widths IDX_W/SONG_W.
- One sub-module, song_rom: address 7 bits, data 12 bits, registered output, contents initialised from a memory file.
- The FSM, index counter, and output registers stay in song_reader.

Test Plan:
1. ROM song0 = {(note 20,dur 4),(note 22,dur 2),(0,0)}. reset, then play=1 at cycle 0 → new_note at cycle 3 with note=20, dur=4. note_done → new_note 3 cycles later with note 22, dur 2. next note_done → song_done=1 held, no further new_note. play=0 → IDLE.
2. Song of 32 nonzero entries; drive note_done after each new_note → exactly 32 new_note pulses, then song_done after index 31.
3. Pause: in WAIT on index 5, play=0 for 10 cycles with note_done pulsed during the pause. play=1 → index 5 re-issued, not 6.
4. Song change: in WAIT on song0 index 3, switch song to 2 → next new_note carries song2 entry 0. song_done stays 0.
5. Reset asserted in WAIT → next cycle all outputs 0, state IDLE. Stray note_done in IDLE → no response.
6. SONG_LOOP_EN defined, 2-note song → after second note_done, one-cycle song_done pulse, then new_note with entry 0 three cycles later.

Source files
------------

// File: rtl/song_reader_pkg.sv
// Shared definitions for the song reader: widths, ROM word layout and FSM states.
package song_reader_pkg;
    localparam int IDX_W     = 5;
    localparam int SONG_W    = 2;
    localparam int NOTES     = 1 << IDX_W;
    localparam int ADDR_W    = SONG_W + IDX_W;
    localparam int ROM_DEPTH = 1 << ADDR_W;
    localparam int DATA_W    = 12;
    localparam int NOTE_W    = 6;

    localparam int NOTE_MSB = 11;
    localparam int NOTE_LSB = 6;
    localparam int DUR_MSB  = 5;
    localparam int DUR_LSB  = 0;

    localparam logic [NOTE_W-1:0] END_MARKER = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    function automatic logic is_end_marker(input logic [DATA_W-1:0] word);
        return word[DUR_MSB:DUR_LSB] == END_MARKER;
    endfunction
endpackage

// File: rtl/song_reader_if.sv
// Control/note-player bundle around the song reader; master is the song reader itself.
interface song_reader_if;
    import song_reader_pkg::*;

    logic              play;
    logic [SONG_W-1:0] song;
    logic              note_done;
    logic [NOTE_W-1:0] note;
    logic [NOTE_W-1:0] duration;
    logic              new_note;
    logic              song_done;

    modport master (
        input  play, song, note_done,
        output note, duration, new_note, song_done
    );

    modport slave (
        output play, song, note_done,
        input  note, duration, new_note, song_done
    );
endinterface

// File: rtl/song_rom.sv
// Song ROM with one-cycle registered read; ROM_IMAGE is the packed image of the song memory file.
module song_rom
    import song_reader_pkg::*;
#(
    parameter logic [ROM_DEPTH*DATA_W-1:0] ROM_IMAGE = '0
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    logic [DATA_W-1:0] data_d, data_q;

    always_comb begin
        data_d = ROM_IMAGE[int'(addr)*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;
endmodule

// File: rtl/song_reader.sv
// Song sequencer: fetches ROM entries and hands them to the note player one at a time.
// Build option: SONG_LOOP_EN restarts the song at its end instead of parking in S_DONE.
module song_reader
    import song_reader_pkg::*;
#(
    parameter logic [ROM_DEPTH*DATA_W-1:0] ROM_IMAGE = '0
) (
    input  logic          clk,
    input  logic          reset,
    song_reader_if.master bus
);
    state_e            state_q, state_d;
    logic              paused_q, paused_d;
    logic [SONG_W-1:0] cur_song_q, cur_song_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [NOTE_W-1:0] dur_q, dur_d;
    logic              new_note_q, new_note_d;
    logic              song_done_q, song_done_d;
    logic              end_song;
    logic [DATA_W-1:0] rom_data;

    song_rom #(.ROM_IMAGE(ROM_IMAGE)) u_rom (
        .clk  (clk),
        .addr ({cur_song_q, index_q}),
        .data (rom_data)
    );

    always_comb begin
        state_d     = state_q;
        paused_d    = paused_q;
        cur_song_d  = cur_song_q;
        index_d     = index_q;
        note_d      = note_q;
        dur_d       = dur_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;
        end_song    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.play) begin
                    cur_song_d = bus.song;
                    index_d    = '0;
                    paused_d   = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH, S_ISSUE, S_WAIT: begin
                // Pause outranks a song change, which outranks note_done.
                if (!bus.play) begin
                    paused_d = 1'b1;
                    state_d  = S_FETCH;
                end else if (bus.song != cur_song_q) begin
                    cur_song_d = bus.song;
                    index_d    = '0;
                    paused_d   = 1'b0;
                    state_d    = S_FETCH;
                end else if (paused_q) begin
                    paused_d = 1'b0;
                end else if (state_q == S_FETCH) begin
                    state_d = S_ISSUE;
                end else if (state_q == S_ISSUE) begin
                    if (is_end_marker(rom_data)) begin
                        end_song = 1'b1;
                    end else begin
                        note_d     = rom_data[NOTE_MSB:NOTE_LSB];
                        dur_d      = rom_data[DUR_MSB:DUR_LSB];
                        new_note_d = 1'b1;
                        state_d    = S_WAIT;
                    end
                end else if (bus.note_done) begin
                    if (index_q == IDX_W'(NOTES-1)) begin
                        end_song = 1'b1;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                if (!bus.play) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef SONG_LOOP_EN
        if (end_song) begin
            song_done_d = 1'b1;
            index_d     = '0;
            state_d     = S_FETCH;
        end
`else
        if (end_song) begin
            state_d = S_DONE;
        end
        song_done_d = (state_d == S_DONE);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            paused_q    <= 1'b0;
            cur_song_q  <= '0;
            index_q     <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            paused_q    <= paused_d;
            cur_song_q  <= cur_song_d;
            index_q     <= index_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
        end
    end

    assign bus.note      = note_q;
    assign bus.duration  = dur_q;
    assign bus.new_note  = new_note_q;
    assign bus.song_done = song_done_q;
endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: per-cycle comparison against a countdown model plus directed literal checks.
module tb_song_reader;
    import song_reader_pkg::*;

    function automatic logic [11:0] song_entry(input int s, input int i);
        logic [11:0] e;
        e = 12'd0;
        case (s)
            0: begin
                if (i == 0) e = {6'd20, 6'd4};
                else if (i == 1) e = {6'd22, 6'd2};
            end
            1: e = {6'(i + 1), 6'((i % 7) + 1)};
            2: begin
                if (i == 0) e = {6'd40, 6'd3};
                else if (i == 1) e = {6'd41, 6'd5};
                else if (i == 2) e = {6'd42, 6'd1};
            end
            3: begin
                if (i == 0) e = {6'd10, 6'd1};
                else if (i == 1) e = {6'd11, 6'd2};
            end
            default: e = 12'd0;
        endcase
        return e;
    endfunction

    function automatic logic [ROM_DEPTH*DATA_W-1:0] build_image();
        logic [ROM_DEPTH*DATA_W-1:0] img;
        img = '0;
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < NOTES; i++)
                img[(s*NOTES + i)*DATA_W +: DATA_W] = song_entry(s, i);
        return img;
    endfunction

    localparam logic [ROM_DEPTH*DATA_W-1:0] IMAGE = build_image();

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       play = 1'b0;
    logic       note_done = 1'b0;
    logic [1:0] song = 2'd0;

    always #5 clk = ~clk;

    song_reader_if bus();
    assign bus.play      = play;
    assign bus.song      = song;
    assign bus.note_done = note_done;

    song_reader #(.ROM_IMAGE(IMAGE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a song run counts down to the edge on which the ROM entry is issued.
    int         m_mode;     // 0 idle, 1 running, 2 finished
    bit         m_paused;
    int         m_pend;
    bit         m_waiting;
    logic [1:0] m_song;
    int         m_idx;
    int         m_note, m_dur;
    bit         m_nn, m_sd;
    logic [11:0] m_e;

    task automatic model_end_song();
`ifdef SONG_LOOP_EN
        m_sd   = 1'b1;
        m_idx  = 0;
        m_pend = 2;
`else
        m_mode = 2;
        m_sd   = 1'b1;
`endif
    endtask

    always @(posedge clk) begin
        m_nn = 1'b0;
`ifdef SONG_LOOP_EN
        m_sd = 1'b0;
`endif
        if (reset) begin
            m_mode = 0; m_paused = 0; m_pend = 0; m_waiting = 0;
            m_song = 0; m_idx = 0; m_note = 0; m_dur = 0; m_sd = 0;
        end else if (m_mode == 0) begin
            if (play) begin
                m_song = song; m_idx = 0; m_pend = 2; m_mode = 1; m_paused = 0;
            end
        end else if (m_mode == 2) begin
            if (!play) begin
                m_mode = 0; m_sd = 0;
            end
        end else begin
            if (!play) begin
                m_paused = 1; m_pend = 0; m_waiting = 0;
            end else if (song != m_song) begin
                m_song = song; m_idx = 0; m_pend = 2; m_paused = 0; m_waiting = 0;
            end else if (m_paused) begin
                m_paused = 0; m_pend = 2;
            end else if (m_pend > 0) begin
                m_pend--;
                if (m_pend == 0) begin
                    m_e = song_entry(int'(m_song), m_idx);
                    if (m_e[5:0] == 6'd0) begin
                        model_end_song();
                    end else begin
                        m_note = int'(m_e[11:6]); m_dur = int'(m_e[5:0]);
                        m_nn = 1'b1; m_waiting = 1'b1;
                    end
                end
            end else if (m_waiting && note_done) begin
                m_waiting = 0;
                if (m_idx == NOTES - 1) model_end_song();
                else begin
                    m_idx++; m_pend = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_note", int'(bus.note), m_note);
            check("cyc_duration", int'(bus.duration), m_dur);
            check("cyc_new_note", int'(bus.new_note), int'(m_nn));
            check("cyc_song_done", int'(bus.song_done), int'(m_sd));
        end
    end

    task automatic wait_nn(input int max, output bit found, output int at);
        found = 1'b0;
        at = 0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (bus.new_note) begin
                found = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic pulse_done();
        note_done = 1'b1;
        @(negedge clk);
        note_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit f;
        int at, c, t, cnt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_note", int'(bus.note), 0);
        check("rst_duration", int'(bus.duration), 0);
        check("rst_new_note", int'(bus.new_note), 0);
        check("rst_song_done", int'(bus.song_done), 0);

`ifdef SONG_LOOP_EN
        // Looping two-note song
        song = 2'd3; play = 1'b1;
        wait_nn(10, f, at);
        check("t6_first_found", int'(f), 1);
        check("t6_first_note", int'(bus.note), 10);
        pulse_done();
        wait_nn(10, f, at);
        check("t6_second_note", int'(bus.note), 11);
        t = at;
        pulse_done();
        @(negedge clk);
        check("t6_done_before", int'(bus.song_done), 0);
        @(negedge clk);
        check("t6_done_pulse", int'(bus.song_done), 1);
        @(negedge clk);
        check("t6_done_after", int'(bus.song_done), 0);
        wait_nn(5, f, at);
        check("t6_restart_found", int'(f), 1);
        check("t6_restart_lat", at - t, 5);
        check("t6_restart_note", int'(bus.note), 10);
`else
        // Three-entry song with end marker
        play = 1'b1; song = 2'd0; c = cyc;
        wait_nn(10, f, at);
        check("t1_found", int'(f), 1);
        check("t1_latency", at - c, 3);
        check("t1_note", int'(bus.note), 20);
        check("t1_duration", int'(bus.duration), 4);
        t = at;
        pulse_done();
        wait_nn(10, f, at);
        check("t1_next_latency", at - t, 3);
        check("t1_next_note", int'(bus.note), 22);
        check("t1_next_duration", int'(bus.duration), 2);
        pulse_done();
        wait_nn(6, f, at);
        check("t1_no_extra_note", int'(f), 0);
        check("t1_song_done", int'(bus.song_done), 1);
        play = 1'b0;
        repeat (2) @(negedge clk);
        check("t1_idle_song_done", int'(bus.song_done), 0);

        // Full 32-entry song
        song = 2'd1; play = 1'b1; cnt = 0;
        for (int i = 0; i < 40; i++) begin
            wait_nn(10, f, at);
            if (!f) break;
            check("t2_note", int'(bus.note), cnt + 1);
            cnt++;
            pulse_done();
        end
        check("t2_count", cnt, 32);
        check("t2_song_done", int'(bus.song_done), 1);
        play = 1'b0;
        repeat (2) @(negedge clk);

        // Pause on index 5 with a stray note_done
        play = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_nn(10, f, at);
            check("t3_lead_found", int'(f), 1);
            pulse_done();
        end
        wait_nn(10, f, at);
        check("t3_idx5_note", int'(bus.note), 6);
        @(negedge clk);
        play = 1'b0;
        repeat (3) @(negedge clk);
        pulse_done();
        repeat (6) @(negedge clk);
        play = 1'b1; c = cyc;
        wait_nn(10, f, at);
        check("t3_resume_found", int'(f), 1);
        check("t3_resume_latency", at - c, 3);
        check("t3_resume_note", int'(bus.note), 6);
        check("t3_resume_duration", int'(bus.duration), 6);

        // Song change while waiting
        @(negedge clk);
        song = 2'd2; c = cyc;
        wait_nn(10, f, at);
        check("t4_latency", at - c, 3);
        check("t4_note", int'(bus.note), 40);
        check("t4_duration", int'(bus.duration), 3);
        check("t4_song_done", int'(bus.song_done), 0);
        pulse_done();
        wait_nn(10, f, at);
        check("t4_second_note", int'(bus.note), 41);
        pulse_done();
        wait_nn(10, f, at);
        check("t4_third_note", int'(bus.note), 42);
        pulse_done();
        repeat (5) @(negedge clk);
        check("t4_end_song_done", int'(bus.song_done), 1);

        // Reset while waiting, then stray note_done in idle
        play = 1'b0;
        repeat (2) @(negedge clk);
        play = 1'b1;
        wait_nn(10, f, at);
        check("t5_found", int'(f), 1);
        @(negedge clk);
        reset = 1'b1; play = 1'b0;
        @(negedge clk);
        check("t5_note", int'(bus.note), 0);
        check("t5_duration", int'(bus.duration), 0);
        check("t5_new_note", int'(bus.new_note), 0);
        check("t5_song_done", int'(bus.song_done), 0);
        reset = 1'b0;
        pulse_done();
        wait_nn(6, f, at);
        check("t5_stray_ignored", int'(f), 0);
        play = 1'b1; c = cyc;
        wait_nn(10, f, at);
        check("t5_restart_latency", at - c, 3);
        check("t5_restart_note", int'(bus.note), 40);
`endif
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
